// File: rtl/fb_sram_pkg.sv
// Shared sizes, state encoding and helpers for the framebuffer SRAM arbiter.
package fb_sram_pkg;

   localparam int ADDR_W              = 18;
   localparam int DATA_W              = 16;
   localparam int CNT_W               = 8;
   localparam int WR_MAX_WAIT_DEFAULT = 8;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_RD0  = 3'd1,
      ST_RD1  = 3'd2,
      ST_WR0  = 3'd3,
      ST_WR1  = 3'd4,
      ST_WR2  = 3'd5,
      ST_TURN = 3'd6
   } state_e;

   // States in which a fresh arbitration decision is taken.
   function automatic logic is_decision(input state_e s);
      return (s == ST_IDLE) || (s == ST_RD1) || (s == ST_WR2);
   endfunction

endpackage

// File: rtl/fb_sram_wait_counter.sv
// Saturating count of reads granted while a write is waiting.
module fb_sram_wait_counter
   import fb_sram_pkg::*;
#(
   parameter int MAX = WR_MAX_WAIT_DEFAULT
) (
   input  logic clk_i,
   input  logic srst_i,
   input  logic inc_i,
   input  logic clr_i,
   output logic at_max_o
);

   localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX);

   logic [CNT_W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (clr_i) begin
         count_d = '0;
      end else if (inc_i && (count_q != MAX_C)) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign at_max_o = (count_q == MAX_C);

endmodule

// File: rtl/framebuffer_sram_arbiter.sv
// Arbitrates the async framebuffer SRAM between capture writes and display reads,
// with read priority, a bounded write wait and a turnaround cycle after writes.
module framebuffer_sram_arbiter
   import fb_sram_pkg::*;
#(
   parameter int WR_MAX_WAIT = WR_MAX_WAIT_DEFAULT
) (
   input  logic              sysClk,
   input  logic              reset,
   input  logic              wr_req,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic              wr_ack,
   input  logic              rd_req,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic              rd_ack,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   output logic              busy,
   output logic [ADDR_W-1:0] sram_addr,
   inout  wire  [DATA_W-1:0] sram_data,
   output logic              sram_ce_n,
   output logic              sram_oe_n,
   output logic              sram_we_n
);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              ce_n_q, ce_n_d;
   logic              oe_n_q, oe_n_d;
   logic              we_n_q, we_n_d;
   logic              drive_q, drive_d;
   logic              wr_ack_q, wr_ack_d;
   logic              rd_ack_q, rd_ack_d;
   logic              rd_valid_q, rd_valid_d;
   logic              decide, grant_wr, grant_rd, at_max;

   fb_sram_wait_counter #(
      .MAX(WR_MAX_WAIT)
   ) u_wait_cnt (
      .clk_i   (sysClk),
      .srst_i  (reset),
      .inc_i   (grant_rd && wr_req),
      .clr_i   (grant_wr),
      .at_max_o(at_max)
   );

   always_comb begin
      decide   = is_decision(state_q);
      grant_wr = decide && wr_req && (at_max || !rd_req);
      grant_rd = decide && rd_req && !grant_wr;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE, ST_RD1: state_d = grant_wr ? ST_WR0 : (grant_rd ? ST_RD0 : ST_IDLE);
         // A read after a write must first let the write data hold release the bus.
         ST_WR2:          state_d = grant_wr ? ST_WR0 : (grant_rd ? ST_TURN : ST_IDLE);
         ST_RD0:          state_d = ST_RD1;
         ST_WR0:          state_d = ST_WR1;
         ST_WR1:          state_d = ST_WR2;
         ST_TURN:         state_d = rd_req ? ST_RD0 : ST_IDLE;
         default:         state_d = ST_IDLE;
      endcase
   end

   // Pin values are computed from the next state so every pin comes straight from a flop.
   always_comb begin
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      rdata_d    = rdata_q;
      ce_n_d     = 1'b1;
      oe_n_d     = 1'b1;
      we_n_d     = 1'b1;
      drive_d    = 1'b0;
      wr_ack_d   = 1'b0;
      rd_ack_d   = 1'b0;
      rd_valid_d = (state_q == ST_RD1);
      if (state_q == ST_RD1) begin
         rdata_d = sram_data;
      end
      case (state_d)
         ST_RD0: begin
            ce_n_d   = 1'b0;
            oe_n_d   = 1'b0;
            rd_ack_d = 1'b1;
            addr_d   = rd_addr;
         end
         ST_RD1: begin
            ce_n_d = 1'b0;
            oe_n_d = 1'b0;
         end
         ST_WR0: begin
            ce_n_d   = 1'b0;
            wr_ack_d = 1'b1;
            addr_d   = wr_addr;
            wdata_d  = wr_data;
         end
         ST_WR1: begin
            ce_n_d  = 1'b0;
            we_n_d  = 1'b0;
            drive_d = 1'b1;
         end
         ST_WR2: begin
            ce_n_d  = 1'b0;
            drive_d = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge sysClk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         addr_q     <= '0;
         wdata_q    <= '0;
         rdata_q    <= '0;
         ce_n_q     <= 1'b1;
         oe_n_q     <= 1'b1;
         we_n_q     <= 1'b1;
         drive_q    <= 1'b0;
         wr_ack_q   <= 1'b0;
         rd_ack_q   <= 1'b0;
         rd_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         rdata_q    <= rdata_d;
         ce_n_q     <= ce_n_d;
         oe_n_q     <= oe_n_d;
         we_n_q     <= we_n_d;
         drive_q    <= drive_d;
         wr_ack_q   <= wr_ack_d;
         rd_ack_q   <= rd_ack_d;
         rd_valid_q <= rd_valid_d;
      end
   end

   assign sram_data = drive_q ? wdata_q : {DATA_W{1'bz}};
   assign sram_addr = addr_q;
   assign sram_ce_n = ce_n_q;
   assign sram_oe_n = oe_n_q;
   assign sram_we_n = we_n_q;
   assign wr_ack    = wr_ack_q;
   assign rd_ack    = rd_ack_q;
   assign rd_valid  = rd_valid_q;
   assign rd_data   = rdata_q;
   assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_framebuffer_sram_arbiter.sv
// Directed and random checks of the framebuffer SRAM arbiter against an async SRAM model.
`timescale 1ns/1ps
module tb_framebuffer_sram_arbiter;

   logic        sysClk = 1'b0;
   logic        reset;
   logic        wr_req, rd_req;
   logic [17:0] wr_addr, rd_addr;
   logic [15:0] wr_data;
   logic        wr_ack, rd_ack, rd_valid, busy;
   logic [15:0] rd_data;
   logic [17:0] sram_addr;
   logic        sram_ce_n, sram_oe_n, sram_we_n;
   wire  [15:0] sram_data;

   int tests = 0;
   int fails = 0;
   int contention_cnt = 0;
   logic wr1_q = 1'b0;
   logic wr2_q = 1'b0;

   logic [15:0] mem [0:262143];
   logic        pl_en = 1'b0;
   logic [17:0] pl_addr = '0;
   logic [15:0] pl_data = '0;

   always #5 sysClk = ~sysClk;

   framebuffer_sram_arbiter #(.WR_MAX_WAIT(8)) dut (
      .sysClk(sysClk), .reset(reset),
      .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
      .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_data(rd_data),
      .rd_valid(rd_valid), .busy(busy), .sram_addr(sram_addr), .sram_data(sram_data),
      .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n)
   );

   // Asynchronous SRAM: drives while selected for read, latches data at the end of a write strobe.
   assign sram_data = (!sram_ce_n && !sram_oe_n && sram_we_n) ? mem[sram_addr] : 16'hzzzz;

   always @(posedge sysClk) begin
      if (pl_en) mem[pl_addr] <= pl_data;
      else if (!sram_ce_n && !sram_we_n) mem[sram_addr] <= sram_data;
   end

   // Output enable must never overlap a write strobe, a deselect, or the cycle right after WR2.
   always @(negedge sysClk) begin
      if (!sram_oe_n && (!sram_we_n || sram_ce_n || wr2_q)) contention_cnt <= contention_cnt + 1;
      wr1_q <= !sram_we_n;
      wr2_q <= wr1_q;
   end

   // An undriven bus resolves to Z or, in two-state simulators, to zero.
   function automatic logic bus_idle();
      return (sram_data === 16'hzzzz) || (sram_data === 16'h0000);
   endfunction

   task automatic tick();
      @(posedge sysClk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1; wr_req = 1'b0; rd_req = 1'b0;
      tick(); tick();
      reset = 1'b0;
   endtask

   task automatic preload(input logic [17:0] a, input logic [15:0] d);
      pl_en = 1'b1; pl_addr = a; pl_data = d;
      tick();
      pl_en = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick(); tick();
      @(negedge sysClk);
      tests++;
      if ({sram_ce_n, sram_oe_n, sram_we_n, wr_ack, rd_ack, rd_valid, busy} !== 7'b1110000) begin
         fails++;
         $display("FAIL reset_ctrl: got %b want 1110000", {sram_ce_n, sram_oe_n, sram_we_n, wr_ack, rd_ack, rd_valid, busy});
      end
      tests++;
      if (rd_data !== 16'h0 || sram_addr !== 18'h0 || !bus_idle()) begin
         fails++;
         $display("FAIL reset_data: rd_data=%h addr=%h bus=%h want 0/0/idle", rd_data, sram_addr, sram_data);
      end
      reset = 1'b0;
      $display("[TB] reset checked");
   endtask

   task automatic test_single_read();
      do_reset();
      preload(18'h1F0F0, 16'hA5C3);
      rd_addr = 18'h1F0F0; rd_req = 1'b1;
      tick(); @(negedge sysClk);
      tests++;
      if ({rd_ack, wr_ack, sram_ce_n, sram_oe_n, sram_we_n, busy} !== 6'b100011 || sram_addr !== 18'h1F0F0) begin
         fails++;
         $display("FAIL read_rd0: got ctrl=%b addr=%h want 100011 1f0f0", {rd_ack, wr_ack, sram_ce_n, sram_oe_n, sram_we_n, busy}, sram_addr);
      end
      tick(); rd_req = 1'b0; @(negedge sysClk);
      tests++;
      if ({rd_ack, rd_valid, sram_ce_n, sram_oe_n} !== 4'b0000) begin
         fails++;
         $display("FAIL read_rd1: got %b want 0000", {rd_ack, rd_valid, sram_ce_n, sram_oe_n});
      end
      tick(); @(negedge sysClk);
      tests++;
      if ({rd_valid, sram_oe_n, sram_ce_n} !== 3'b111 || rd_data !== 16'hA5C3) begin
         fails++;
         $display("FAIL read_valid: got ctrl=%b data=%h want 111 a5c3", {rd_valid, sram_oe_n, sram_ce_n}, rd_data);
      end
      tick(); @(negedge sysClk);
      tests++;
      if (rd_valid !== 1'b0 || busy !== 1'b0) begin
         fails++;
         $display("FAIL read_end: rd_valid=%b busy=%b want 0 0", rd_valid, busy);
      end
      $display("[TB] read  addr=1f0f0 data=%h", rd_data);
   endtask

   task automatic test_single_write();
      do_reset();
      wr_addr = 18'h00010; wr_data = 16'h1234; wr_req = 1'b1;
      tick(); @(negedge sysClk);
      tests++;
      if ({wr_ack, rd_ack, sram_ce_n, sram_oe_n, sram_we_n} !== 5'b10011 || sram_addr !== 18'h10 || !bus_idle()) begin
         fails++;
         $display("FAIL write_wr0: got ctrl=%b addr=%h bus=%h want 10011 00010 idle", {wr_ack, rd_ack, sram_ce_n, sram_oe_n, sram_we_n}, sram_addr, sram_data);
      end
      tick(); wr_req = 1'b0; wr_data = 16'h0000; @(negedge sysClk);
      tests++;
      if ({wr_ack, sram_we_n, sram_oe_n, sram_ce_n} !== 4'b0010 || sram_data !== 16'h1234) begin
         fails++;
         $display("FAIL write_wr1: got ctrl=%b bus=%h want 0010 1234", {wr_ack, sram_we_n, sram_oe_n, sram_ce_n}, sram_data);
      end
      tick(); @(negedge sysClk);
      tests++;
      if ({sram_we_n, sram_oe_n, sram_ce_n} !== 3'b110 || sram_data !== 16'h1234 || sram_addr !== 18'h10) begin
         fails++;
         $display("FAIL write_wr2: got ctrl=%b bus=%h addr=%h want 110 1234 00010", {sram_we_n, sram_oe_n, sram_ce_n}, sram_data, sram_addr);
      end
      tick(); @(negedge sysClk);
      tests++;
      if ({sram_ce_n, sram_we_n, busy} !== 3'b110 || !bus_idle()) begin
         fails++;
         $display("FAIL write_end: got ctrl=%b bus=%h want 110 idle", {sram_ce_n, sram_we_n, busy}, sram_data);
      end
      tests++;
      if (mem[18'h10] !== 16'h1234) begin
         fails++;
         $display("FAIL write_mem: got %h want 1234", mem[18'h10]);
      end
      $display("[TB] write addr=00010 data=%h", mem[18'h10]);
   endtask

   task automatic test_arbitration();
      int rd_pos[$];
      int wr_pos[$];
      int n_before = 0;
      int n_between = 0;
      int first_after = 0;
      int bad_data = 0;
      do_reset();
      preload(18'h00100, 16'hBEEF);
      rd_addr = 18'h00100; wr_addr = 18'h00200; wr_data = 16'h7777;
      rd_req = 1'b1; wr_req = 1'b1;
      for (int c = 1; c <= 38; c++) begin
         tick(); @(negedge sysClk);
         if (rd_ack) rd_pos.push_back(c);
         if (wr_ack) wr_pos.push_back(c);
         if (rd_valid && rd_data !== 16'hBEEF) bad_data++;
      end
      rd_req = 1'b0; wr_req = 1'b0;
      tick(); tick(); tick();
      foreach (rd_pos[i]) begin
         if (rd_pos[i] < 17) n_before++;
         else if (rd_pos[i] < 37) n_between++;
         if (rd_pos[i] > 17 && first_after == 0) first_after = rd_pos[i];
      end
      tests++;
      if (wr_pos.size() != 2 || wr_pos[0] != 17 || wr_pos[1] != 37) begin
         fails++;
         $display("FAIL arb_write_slots: got %0d writes first=%0d want 2 writes at 17 37", wr_pos.size(), (wr_pos.size() > 0) ? wr_pos[0] : -1);
      end
      tests++;
      if (n_before != 8 || n_between != 8) begin
         fails++;
         $display("FAIL arb_read_count: got %0d/%0d reads want 8/8", n_before, n_between);
      end
      tests++;
      if (first_after != 21) begin
         fails++;
         $display("FAIL arb_turn_gap: got first read after write at %0d want 21", first_after);
      end
      tests++;
      if (bad_data != 0) begin
         fails++;
         $display("FAIL arb_read_data: got %0d wrong reads want 0", bad_data);
      end
      $display("[TB] arbitration reads=%0d writes=%0d", rd_pos.size(), wr_pos.size());
   endtask

   task automatic test_write_then_read();
      do_reset();
      wr_addr = 18'h2AAAA; wr_data = 16'h5A5A; wr_req = 1'b1;
      tick(); @(negedge sysClk);
      tests++;
      if (wr_ack !== 1'b1) begin
         fails++;
         $display("FAIL wtr_wr_ack: got %b want 1", wr_ack);
      end
      tick(); wr_req = 1'b0; rd_req = 1'b1; rd_addr = 18'h2AAAA;
      tick(); tick(); @(negedge sysClk);
      tests++;
      if ({sram_ce_n, sram_oe_n, sram_we_n, rd_ack, busy} !== 5'b11101 || !bus_idle()) begin
         fails++;
         $display("FAIL wtr_turn: got ctrl=%b bus=%h want 11101 idle", {sram_ce_n, sram_oe_n, sram_we_n, rd_ack, busy}, sram_data);
      end
      tick(); @(negedge sysClk);
      tests++;
      if ({rd_ack, sram_oe_n} !== 2'b10) begin
         fails++;
         $display("FAIL wtr_rd0: got %b want 10", {rd_ack, sram_oe_n});
      end
      tick(); rd_req = 1'b0;
      tick(); @(negedge sysClk);
      tests++;
      if (rd_valid !== 1'b1 || rd_data !== 16'h5A5A) begin
         fails++;
         $display("FAIL wtr_data: got valid=%b data=%h want 1 5a5a", rd_valid, rd_data);
      end
      tests++;
      if (contention_cnt != 0) begin
         fails++;
         $display("FAIL wtr_contention: got %0d overlaps want 0", contention_cnt);
      end
      $display("[TB] write-then-read addr=2aaaa data=%h", rd_data);
   endtask

   task automatic test_reset_mid_access();
      int stray = 0;
      do_reset();
      wr_addr = 18'h00003; wr_data = 16'hCAFE; wr_req = 1'b1;
      tick(); tick(); wr_req = 1'b0;
      @(negedge sysClk);
      tests++;
      if (sram_we_n !== 1'b0) begin
         fails++;
         $display("FAIL rst_wr1_entry: we_n=%b want 0", sram_we_n);
      end
      reset = 1'b1;
      tick(); @(negedge sysClk);
      tests++;
      if ({sram_ce_n, sram_oe_n, sram_we_n, wr_ack, busy} !== 5'b11100 || !bus_idle()) begin
         fails++;
         $display("FAIL rst_mid_write: got ctrl=%b bus=%h want 11100 idle", {sram_ce_n, sram_oe_n, sram_we_n, wr_ack, busy}, sram_data);
      end
      reset = 1'b0;
      rd_addr = 18'h00004; rd_req = 1'b1;
      tick(); tick(); rd_req = 1'b0;
      reset = 1'b1;
      tick(); reset = 1'b0;
      for (int c = 0; c < 6; c++) begin
         @(negedge sysClk);
         if (wr_ack || rd_ack || rd_valid) stray++;
         tick();
      end
      tests++;
      if (stray != 0 || busy !== 1'b0) begin
         fails++;
         $display("FAIL rst_no_ack: got %0d stray pulses busy=%b want 0 0", stray, busy);
      end
      $display("[TB] reset mid-access checked");
   endtask

   task automatic test_random();
      logic [15:0] shadow [16];
      logic [15:0] exp_q[$];
      logic [15:0] e;
      logic wa, ra;
      int nrd = 0;
      int nwr = 0;
      int c0;
      do_reset();
      for (int a = 0; a < 16; a++) begin
         e = 16'($urandom);
         preload(18'(a), e);
         shadow[a] = e;
      end
      c0 = contention_cnt;
      for (int c = 0; c < 3100; c++) begin
         @(negedge sysClk);
         if (wr_ack) begin shadow[wr_addr[3:0]] = wr_data; nwr++; end
         if (rd_ack) exp_q.push_back(shadow[rd_addr[3:0]]);
         if (rd_valid) begin
            tests++;
            if (exp_q.size() == 0) begin
               fails++;
               $display("FAIL rand_unexpected_valid: got data=%h want no rd_valid", rd_data);
            end else begin
               e = exp_q.pop_front();
               nrd++;
               if (rd_data !== e) begin
                  fails++;
                  $display("FAIL rand_read: got %h want %h", rd_data, e);
               end
            end
         end
         wa = wr_ack; ra = rd_ack;
         tick();
         // Last 100 cycles only retire outstanding requests.
         if (!wr_req || wa) begin
            wr_req = (c < 3000) && ($urandom_range(0, 2) != 0);
            wr_addr = 18'($urandom_range(0, 15)); wr_data = 16'($urandom);
         end
         if (!rd_req || ra) begin
            rd_req = (c < 3000) && ($urandom_range(0, 2) != 0);
            rd_addr = 18'($urandom_range(0, 15));
         end
      end
      tests++;
      if (exp_q.size() != 0 || busy !== 1'b0 || nrd < 100 || nwr < 100) begin
         fails++;
         $display("FAIL rand_drain: pending=%0d busy=%b reads=%0d writes=%0d want 0 0 >=100 >=100", exp_q.size(), busy, nrd, nwr);
      end
      tests++;
      if (contention_cnt != c0) begin
         fails++;
         $display("FAIL rand_contention: got %0d overlaps want 0", contention_cnt - c0);
      end
      $display("[TB] random reads=%0d writes=%0d", nrd, nwr);
   endtask

   initial begin
      reset = 1'b1; wr_req = 1'b0; rd_req = 1'b0;
      wr_addr = '0; wr_data = '0; rd_addr = '0;
      test_reset();
      test_single_read();
      test_single_write();
      test_arbitration();
      test_write_then_read();
      test_reset_mid_access();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

endmodule
